// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle fetch/decode/execute controller with a 4x8 register file driving an external ALU.
// Optional macro CTRL_SINGLE_STEP_EN adds a step input and a PAUSE state between instructions.
`default_nettype none
module cpu_ctrl #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [7:0]      imem_rdata,
  output logic [7:0]      alu_rs1,
  output logic [7:0]      alu_rs2,
  output logic [2:0]      alu_opcode,
  output logic            alu_en,
  input  logic [7:0]      alu_rd,
  input  logic            alu_is_zero,
  output logic [7:0]      out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            halted
`ifdef CTRL_SINGLE_STEP_EN
  ,
  input  logic            step
`endif
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_JZ   = 3'd5;
  localparam logic [2:0] OP_OUT  = 3'd6;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_FETCH_IMM = 3'd2,
    S_EXEC      = 3'd3,
    S_OUT_WAIT  = 3'd4,
    S_HALTED    = 3'd5
`ifdef CTRL_SINGLE_STEP_EN
    ,
    S_PAUSE     = 3'd6
`endif
  } state_t;

  // S_DONE is where every completed instruction lands; S_INIT is the post-reset state.
`ifdef CTRL_SINGLE_STEP_EN
  localparam state_t S_DONE = S_PAUSE;
  localparam state_t S_INIT = S_PAUSE;
`else
  localparam state_t S_DONE = S_FETCH;
  localparam state_t S_INIT = S_FETCH;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;
  logic [7:0]      r_imm;
  logic [7:0]      r_regs [4];
  logic [2:0]      w_op;
  logic [1:0]      w_ra;
  logic [1:0]      w_rb;
  logic            w_unused_ir4;

  assign w_op         = r_ir[7:5];
  assign w_ra         = r_ir[3:2];
  assign w_rb         = r_ir[1:0];
  assign w_unused_ir4 = r_ir[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FETCH:     if (imem_ack) w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_NOP:                 w_state_nxt = S_DONE;
          OP_LDI, OP_JZ:          w_state_nxt = S_FETCH_IMM;
          OP_ADD, OP_AND, OP_XOR: w_state_nxt = S_EXEC;
          OP_OUT:                 w_state_nxt = S_OUT_WAIT;
          default:                w_state_nxt = S_HALTED;
        endcase
      end
      S_FETCH_IMM: if (imem_ack) w_state_nxt = (w_op == OP_LDI) ? S_DONE : S_EXEC;
      S_EXEC:      w_state_nxt = S_DONE;
      S_OUT_WAIT:  if (out_ready) w_state_nxt = S_DONE;
      S_HALTED:    w_state_nxt = S_HALTED;
`ifdef CTRL_SINGLE_STEP_EN
      S_PAUSE:     if (step) w_state_nxt = S_FETCH;
`endif
      default:     w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_imm <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir <= imem_rdata;
            r_pc <= r_pc + PC_W'(1);
          end
        end
        S_FETCH_IMM: begin
          if (imem_ack) begin
            r_imm <= imem_rdata;
            r_pc  <= r_pc + PC_W'(1);
            if (w_op == OP_LDI) r_regs[w_ra] <= imem_rdata;
          end
        end
        S_EXEC: begin
          if (w_op == OP_ADD || w_op == OP_AND || w_op == OP_XOR)
            r_regs[w_ra] <= alu_rd;
          else if (w_op == OP_JZ && alu_is_zero)
            r_pc <= PC_W'(r_imm);
        end
        default: ;
      endcase
    end
  end

  // The request is gated by rst_n so it drops the instant reset asserts, even though
  // the reset state itself is a fetch state.
  always_comb begin
    imem_addr  = r_pc;
    imem_req   = rst_n && (r_state == S_FETCH || r_state == S_FETCH_IMM);
    alu_en     = (r_state == S_EXEC);
    alu_opcode = alu_en ? w_op : 3'd0;
    alu_rs1    = alu_en ? r_regs[w_ra] : 8'd0;
    alu_rs2    = alu_en ? r_regs[w_rb] : 8'd0;
    out_valid  = (r_state == S_OUT_WAIT);
    out_data   = out_valid ? r_regs[w_ra] : 8'd0;
    halted     = (r_state == S_HALTED);
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: scoreboard bench; an ISA-level model predicts fetch addresses, ALU issues and OUT bytes.
`default_nettype none
module tb_cpu_ctrl;
  localparam int PC_W = 8;
`ifdef CTRL_SINGLE_STEP_EN
  localparam logic REQ_AFTER_RST = 1'b0;
`else
  localparam logic REQ_AFTER_RST = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] imem_addr;
  logic       imem_req, imem_ack;
  logic [7:0] imem_rdata;
  logic [7:0] alu_rs1, alu_rs2, alu_rd;
  logic [2:0] alu_opcode;
  logic       alu_en, alu_is_zero;
  logic [7:0] out_data;
  logic       out_valid, out_ready, halted;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step;
  assign step = 1'b1;
`endif

  always #5 clk = ~clk;

  cpu_ctrl #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_opcode(alu_opcode), .alu_en(alu_en),
    .alu_rd(alu_rd), .alu_is_zero(alu_is_zero),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .halted(halted)
`ifdef CTRL_SINGLE_STEP_EN
    , .step(step)
`endif
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int wait_cfg = 0;     // -1: random 0..2 wait cycles per fetch
  int ready_mode = 0;   // 0: always ready, 1: random, 2: low for 4 valid cycles
  int wcnt = 0;
  int vcnt = 0;
  logic junk = 1'b0;
  logic rnd_ready = 1'b0;
  logic [7:0]  mem [256];
  logic [7:0]  q_fetch [$];
  logic [18:0] q_alu [$];
  logic [7:0]  q_out [$];

  function automatic int next_wait();
    return (wait_cfg >= 0) ? wait_cfg : int'($urandom_range(0, 2));
  endfunction

  // Memory, ALU and consumer models
  assign imem_ack   = imem_req ? (wcnt == 0) : junk;
  assign imem_rdata = mem[imem_addr];
  assign out_ready  = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? (vcnt >= 4) : rnd_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= next_wait();
      vcnt <= 0;
    end else begin
      if (imem_req && imem_ack)   wcnt <= next_wait();
      else if (imem_req && wcnt > 0) wcnt <= wcnt - 1;
      vcnt      <= out_valid ? vcnt + 1 : 0;
      junk      <= 1'($urandom);
      rnd_ready <= ($urandom_range(0, 2) != 0);
    end
  end

  always_comb begin
    alu_rd      = 8'h5A;
    alu_is_zero = 1'b1;
    if (alu_en) begin
      alu_is_zero = (alu_rs1 == 8'd0);
      case (alu_opcode)
        3'd2:    alu_rd = alu_rs1 + alu_rs2;
        3'd3:    alu_rd = alu_rs1 & alu_rs2;
        3'd4:    alu_rd = alu_rs1 ^ alu_rs2;
        default: alu_rd = 8'h00;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {25'd0, imem_req, imem_addr, alu_en, alu_opcode, alu_rs1, alu_rs2, out_valid, out_data, halted};
  endfunction

  // Monitor: pops expectations whenever the DUT presents a fetch, an ALU issue or an output
  initial begin
    logic [7:0] prev_addr;
    logic [7:0] prev_odata;
    bit         prev_wait;
    bit         prev_ostall;
    int         vcyc;
    prev_addr = 0; prev_odata = 0; prev_wait = 0; prev_ostall = 0; vcyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || !chk_en) begin
        prev_wait = 0; prev_ostall = 0; vcyc = 0;
      end else begin
        if (imem_req) begin
          if (prev_wait) chk("fetch_addr_stable", imem_addr, prev_addr);
          if (imem_ack) begin
            if (q_fetch.size() == 0) chk("fetch_unexpected", imem_addr, 64'hFFFF);
            else chk("fetch_addr", imem_addr, q_fetch.pop_front());
          end
        end
        prev_wait = imem_req && !imem_ack;
        prev_addr = imem_addr;
        if (alu_en) begin
          if (q_alu.size() == 0) chk("alu_unexpected", {alu_opcode, alu_rs1, alu_rs2}, 64'hFFFFFF);
          else chk("alu_issue", {alu_opcode, alu_rs1, alu_rs2}, q_alu.pop_front());
        end else begin
          chk("alu_idle", {alu_opcode, alu_rs1, alu_rs2}, 0);
        end
        if (prev_ostall) chk("out_hold", {out_valid, out_data}, {1'b1, prev_odata});
        if (out_valid) begin
          vcyc++;
          chk("out_no_fetch", imem_req, 0);
          if (out_ready) begin
            if (q_out.size() == 0) chk("out_unexpected", out_data, 64'hFFFF);
            else chk("out_data", out_data, q_out.pop_front());
            if (ready_mode == 2) chk("out_stall_cycles", vcyc, 5);
            vcyc = 0;
          end
        end
        prev_ostall = out_valid && !out_ready;
        prev_odata  = out_data;
      end
    end
  end

  // ISA-level reference: walks the program, queues expectations, sums nominal cycles
  task automatic model(output bit ok, output int lat, output int nf, output int no, output int ni);
    logic [7:0] regs [4];
    logic [7:0] pc, b, x, y;
    logic [2:0] op;
    bit done;
    q_fetch.delete(); q_alu.delete(); q_out.delete();
    for (int i = 0; i < 4; i++) regs[i] = 0;
    pc = 0; done = 0; lat = 0; nf = 0; no = 0; ni = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      b = mem[pc]; q_fetch.push_back(pc); pc = pc + 1; nf++; ni++;
      op = b[7:5]; x = regs[b[3:2]]; y = regs[b[1:0]];
      case (op)
        3'd0: lat += 2;
        3'd1: begin
          q_fetch.push_back(pc); regs[b[3:2]] = mem[pc]; pc = pc + 1; nf++; lat += 3;
        end
        3'd2, 3'd3, 3'd4: begin
          q_alu.push_back({op, x, y});
          regs[b[3:2]] = (op == 3'd2) ? x + y : (op == 3'd3) ? (x & y) : (x ^ y);
          lat += 3;
        end
        3'd5: begin
          q_fetch.push_back(pc); q_alu.push_back({op, x, y});
          pc = (x == 0) ? mem[pc] : pc + 1; nf++; lat += 4;
        end
        3'd6: begin q_out.push_back(x); no++; lat += 3; end
        default: begin lat += 2; done = 1; end
      endcase
    end
    ok = done;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
  endtask

  task automatic load(input logic [7:0] base, input int len, input logic [127:0] p);
    for (int i = 0; i < len; i++) mem[8'(base + i)] = p[8*(len-1-i) +: 8];
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    @(posedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic run_prog(input int wcfg, input int rmode, input bit chk_lat, output bit ran);
    bit ok;
    int lat, nf, no, ni, cyc, exp_lat;
    model(ok, lat, nf, no, ni);
    ran = ok;
    if (ok) begin
      wait_cfg = wcfg; ready_mode = rmode;
      do_reset();
      chk_en = 1'b1; cyc = 0;
      while (!halted && cyc < 20000) begin @(negedge clk); cyc++; end
      chk("halted", halted, 1);
      chk("halt_no_req", imem_req, 0);
      chk("fetch_q_empty", q_fetch.size(), 0);
      chk("alu_q_empty", q_alu.size(), 0);
      chk("out_q_empty", q_out.size(), 0);
      if (chk_lat) begin
        exp_lat = lat + wcfg * nf + ((rmode == 2) ? 4 * no : 0);
`ifdef CTRL_SINGLE_STEP_EN
        exp_lat += ni;
`endif
        chk("latency", cyc - 1, exp_lat);
      end
      chk_en = 1'b0;
    end
  endtask

  task automatic abort_check(input string name);
    #1 rst_n = 1'b0;
    #1 chk(name, all_outs(), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    #1 chk("first_fetch_after_reset", {imem_req, imem_addr}, {REQ_AFTER_RST, 8'h00});
  endtask

  initial begin
    bit ran;
    int cyc;
    clear_mem();
    load(8'h00, 7, 128'h21_05_25_03_41_C0_E0);
    run_prog(0, 0, 1, ran);
    run_prog(3, 0, 1, ran);

    clear_mem();
    load(8'h00, 11, 128'h21_FF_25_02_41_C0_61_C0_81_C0_E0);
    run_prog(0, 0, 1, ran);
    run_prog(3, 0, 1, ran);

    clear_mem();
    load(8'h00, 2, 128'hA8_10);
    load(8'h10, 6, 128'h21_01_A0_40_C0_E0);
    run_prog(0, 2, 1, ran);

    clear_mem();
    load(8'h00, 2, 128'hA0_FE);
    load(8'hFE, 2, 128'h00_25);
    run_prog(0, 0, 1, ran);

    for (int r = 0; r < 24; r++) begin
      ran = 0;
      for (int t = 0; t < 50 && !ran; t++) begin
        clear_mem();
        for (int i = 0; i < 40; i++) mem[i] = 8'($urandom);
        if (r < 4) run_prog(1, 2, 1, ran);
        else       run_prog(-1, 1, 0, ran);
      end
    end

    // Reset aborting a pending immediate fetch and a stalled OUT
    clear_mem();
    load(8'h00, 4, 128'h21_05_C0_E0);
    wait_cfg = 2; ready_mode = 2; chk_en = 1'b0;
    do_reset();
    cyc = 0;
    while (!(imem_req && imem_addr == 8'h01) && cyc < 200) begin @(negedge clk); cyc++; end
    chk("reach_fetch_imm", {imem_req, imem_addr}, {1'b1, 8'h01});
    abort_check("reset_in_fetch_imm");
    cyc = 0;
    while (!out_valid && cyc < 200) begin @(negedge clk); cyc++; end
    chk("out_before_abort", {out_valid, out_data}, {1'b1, 8'h05});
    abort_check("reset_in_out_wait");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Multi-cycle fetch/decode/execute controller with a 4x8 register file, sitting directly upstream of the 8-bit ALU.
- Fetches 8-bit instructions from instruction memory and drives the ALU operand, opcode and enable inputs.
- Writes the ALU result back to the register file and uses the ALU zero flag for conditional branches.

Parameters:
PC_W, 8, program-counter / instruction-address width; PC wraps modulo 2^PC_W

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_addr  out  PC_W  instruction fetch address
imem_req  out  1  fetch request, held until imem_ack
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  8  fetched byte
alu_rs1  out  8  ALU operand A = R[ra]
alu_rs2  out  8  ALU operand B = R[rb]
alu_opcode  out  3  ALU operation = ir[7:5]
alu_en  out  1  ALU enable, high only in EXEC
alu_rd  in  8  ALU result
alu_is_zero  in  1  ALU flag, 1 when alu_rs1==0
out_data  out  8  output port data
out_valid  out  1  output data valid
out_ready  in  1  consumer accepts out_data
halted  out  1  HALT executed
step  in  1  single-step pulse; present only with CTRL_SINGLE_STEP_EN

Behaviour:
- Instruction format: op=[7:5], bit4 ignored, ra=[3:2], rb=[1:0].
- Opcodes:
  - 000 NOP
  - 001 LDI: 2-byte; R[ra]<=imm
  - 010 ADD: R[ra]<=R[ra]+R[rb], mod 256, no carry
  - 011 AND: R[ra]<=R[ra]&R[rb]
  - 100 XOR: R[ra]<=R[ra]^R[rb]
  - 101 JZ: 2-byte; if R[ra]==0 then pc<=imm, else fall through
  - 110 OUT: emit R[ra]
  - 111 HALT
- Reset (async assert, sync-safe release):
  - state=FETCH, pc=0, ir=0, imm=0, R0..R3=0.
  - imem_req=0, imem_addr=0, alu_en=0, alu_opcode=0, alu_rs1=alu_rs2=0.
  - out_valid=0, out_data=0, halted=0.
  - Reset mid-operation aborts everything, including a pending fetch or OUT.
- Fetch handshake:
  - imem_req=1 and imem_addr=pc held stable until the cycle imem_ack=1.
  - imem_rdata is captured in the ack cycle; imem_req drops the next cycle.
  - imem_ack with imem_req=0 is ignored.
  - Zero-wait ack is allowed, giving a minimum of 1 cycle per fetch.
- States:
  - FETCH: request at pc; on ack ir<=rdata, pc<=pc+1, go to DECODE.
  - DECODE (1 cycle):
    - NOP -> FETCH
    - LDI, JZ -> FETCH_IMM
    - ADD, AND, XOR -> EXEC
    - OUT -> OUT_WAIT
    - HALT -> HALTED
  - FETCH_IMM: request at pc; on ack imm<=rdata, pc<=pc+1.
    - LDI: write R[ra]<=rdata in the same edge, go to FETCH.
    - JZ: go to EXEC.
  - EXEC (1 cycle):
    - alu_en=1, alu_rs1=R[ra], alu_rs2=R[rb], alu_opcode=op.
    - ADD/AND/XOR: R[ra]<=alu_rd at the end of the cycle.
    - JZ: if alu_is_zero then pc<=imm; no register write.
    - Go to FETCH.
    - ALU outputs are ignored in every other state.
  - OUT_WAIT: out_valid=1, out_data=R[ra]; both stable until out_ready=1; then out_valid<=0, go to FETCH.
  - HALTED: halted=1; stays here until reset. imem_req=0, alu_en=0.
- Outside EXEC: alu_en=0, alu_opcode=0, alu_rs1=alu_rs2=0.
- ra==rb is legal; both ALU operands read the same register.
- Latency with zero-wait memory:
  - NOP: 2 cycles
  - ALU op: 3 cycles
  - LDI: 3 cycles
  - JZ: 4 cycles
  - OUT: 3 cycles with out_ready=1
- pc wrap: 0xFF+1 -> 0x00 (PC_W=8). An immediate fetch at 0xFF reads its immediate from 0x00.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds step input and a PAUSE state.
  - Every transition that would enter FETCH (end of an instruction) enters PAUSE instead.
  - PAUSE -> FETCH on a cycle with step=1. step held high advances one instruction per visit to PAUSE.
  - After reset the block starts in PAUSE, not FETCH.
  - HALT still goes to HALTED.
- Not defined: no step port, no PAUSE state; free-running as above.

Test Plan:
- Reset, zero-wait memory, program {0x21,0x05, 0x25,0x03, 0x41, 0xC0, 0xE0} -> R0=5, R1=3; ADD R0+=R1 gives 0x08; out_valid with out_data=0x08; then halted=1, imem_req=0.
- LDI R0,0xFF; LDI R1,0x02; ADD -> R0=0x01 (wrap); AND R0&R1 -> 0x00; XOR R0^R1 -> 0x02.
- JZ R2 (=0) to 0x10 -> pc=0x10 and the next fetch address is 0x10. JZ R0 (=1) -> fall through to pc+2; alu_en high exactly 1 cycle per JZ.
- imem_ack delayed 3 cycles per fetch -> imem_addr/imem_req stable throughout the wait; results identical to the zero-wait run.
- OUT with out_ready low 4 cycles -> out_valid/out_data held for 4 cycles; accepted on the 5th; no fetch issued before acceptance.
- rst_n asserted during FETCH_IMM and during OUT_WAIT -> all outputs return to reset values immediately; after release the first fetch is at 0x00. With CTRL_SINGLE_STEP_EN: no fetch until step=1; each step pulse retires one instruction.
